// File: rtl/htif_mem_bridge.sv
// htif_mem_bridge: host request/response front end for the HTIF port of the
// shared byte memory. Decodes one header beat per command, then streams
// doubleword-aligned write bursts onto hw_* or read bursts from hr_* back onto
// the response stream.
`timescale 1ns/1ps

module htif_mem_bridge #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 64,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_bits,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_bits,
  output logic [ADDR_WIDTH-1:0] hw_addr,
  output logic [DATA_WIDTH-1:0] hw_data,
  output logic [MASK_WIDTH-1:0] hw_mask,
  output logic                  hw_en,
  output logic [ADDR_WIDTH-1:0] hr_addr,
  input  logic [DATA_WIDTH-1:0] hr_data,
  output logic                  busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_WRESP = 3'd2,
    ST_RDATA = 3'd3,
    ST_ERESP = 3'd4
  } state_t;

  // One doubleword step; the sum wraps naturally at the top of the memory.
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = {{(ADDR_WIDTH-4){1'b0}}, 4'b1000};

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [ADDR_WIDTH-1:0]   addr_nxt_s;
  logic [7:0]              cnt_r;
  logic [7:0]              cnt_nxt_s;
  logic [7:0]              nm1_r;
  logic [7:0]              nm1_nxt_s;
  logic                    req_ready_s;
  logic                    resp_valid_s;
  logic [DATA_WIDTH-1:0]   resp_bits_s;
  logic                    hw_en_s;
  logic [DATA_WIDTH-1:0]   status_ok_s;
  logic [DATA_WIDTH-1:0]   status_err_s;
  logic [ADDR_WIDTH-1:0]   hdr_addr_s;

  // Header address with the low three bits forced to a doubleword boundary.
  assign hdr_addr_s   = {req_bits[32+ADDR_WIDTH-1:35], 3'b000};
  // Status beats echo the burst length field; low two bits carry the status code.
  assign status_ok_s  = {{(DATA_WIDTH-16){1'b0}}, nm1_r, 6'b000000, 2'b00};
  assign status_err_s = {{(DATA_WIDTH-16){1'b0}}, nm1_r, 6'b000000, 2'b11};

  // Next-state, counter update and handshake decode for the command FSM.
  always_comb begin
    state_nxt_s  = state_r;
    addr_nxt_s   = addr_r;
    cnt_nxt_s    = cnt_r;
    nm1_nxt_s    = nm1_r;
    req_ready_s  = 1'b0;
    resp_valid_s = 1'b0;
    resp_bits_s  = {DATA_WIDTH{1'b0}};
    hw_en_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        req_ready_s = 1'b1;
        if (req_valid) begin
          addr_nxt_s = hdr_addr_s;
          cnt_nxt_s  = req_bits[15:8];
          nm1_nxt_s  = req_bits[15:8];
          case (req_bits[1:0])
            2'b00:   state_nxt_s = ST_RDATA;
            2'b01:   state_nxt_s = ST_WDATA;
            default: state_nxt_s = ST_ERESP;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WDATA: begin
        req_ready_s = 1'b1;
        hw_en_s     = req_valid;
        if (req_valid) begin
          addr_nxt_s = addr_r + ADDR_STEP;
          cnt_nxt_s  = cnt_r - 8'd1;
          if (cnt_r == 8'd0) begin
            state_nxt_s = ST_WRESP;
          end else begin
            state_nxt_s = ST_WDATA;
          end
        end else begin
          state_nxt_s = ST_WDATA;
        end
      end
      ST_WRESP: begin
        resp_valid_s = 1'b1;
        resp_bits_s  = status_ok_s;
        if (resp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WRESP;
        end
      end
      ST_RDATA: begin
        resp_valid_s = 1'b1;
        resp_bits_s  = hr_data;
        if (resp_ready) begin
          addr_nxt_s = addr_r + ADDR_STEP;
          cnt_nxt_s  = cnt_r - 8'd1;
          if (cnt_r == 8'd0) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_RDATA;
          end
        end else begin
          state_nxt_s = ST_RDATA;
        end
      end
      ST_ERESP: begin
        resp_valid_s = 1'b1;
        resp_bits_s  = status_err_s;
        if (resp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ERESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, address, beat counter and echoed length registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      addr_r  <= {ADDR_WIDTH{1'b0}};
      cnt_r   <= 8'd0;
      nm1_r   <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      addr_r  <= addr_nxt_s;
      cnt_r   <= cnt_nxt_s;
      nm1_r   <= nm1_nxt_s;
    end
  end

  // Reset holds the FSM in IDLE, but req_ready must also read low while
  // rst_n itself is low, so it is gated directly.
  assign req_ready  = req_ready_s & rst_n;
  assign resp_valid = resp_valid_s;
  assign resp_bits  = resp_bits_s;
  assign hw_en      = hw_en_s;
  assign hw_addr    = addr_r;
  assign hw_data    = req_bits;
  assign hw_mask    = {MASK_WIDTH{1'b1}};
  assign hr_addr    = addr_r;
  assign busy       = (state_r != ST_IDLE);

endmodule

// File: doc/htif_mem_bridge.md
Name: htif_mem_bridge

Overview:
- Host-side front end for the HTIF port of the shared async-read byte memory.
- Accepts a 64-bit request stream from the host (header beat, then data beats) and turns it into aligned doubleword bursts.
- Writes go out on the memory's hw_* write port. Reads are served through hr_addr/hr_data.
- Read data and write acknowledgements return on a 64-bit response stream with valid/ready backpressure.

Parameters:
- ADDR_WIDTH, 21, byte-address width of the memory (log2 of 2 MiB).
- DATA_WIDTH, 64, host and memory HTIF data width; fixed at 64 for this block.
- MASK_WIDTH, DATA_WIDTH/8, byte-mask width on hw_mask.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request beat valid
- req_ready  out  1  request beat accepted when valid&&ready
- req_bits  in  64  header or write-data beat
- resp_valid  out  1  response beat valid
- resp_ready  in  1  host accepts response beat
- resp_bits  out  64  read data or status beat
- hw_addr  out  ADDR_WIDTH  memory write byte address
- hw_data  out  64  memory write data
- hw_mask  out  MASK_WIDTH  memory byte mask
- hw_en  out  1  memory write enable, sampled at posedge clk
- hr_addr  out  ADDR_WIDTH  memory read byte address
- hr_data  in  64  memory combinational read data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - Address and beat counters clear to 0.
  - Outputs while rst_n is low: req_ready=0, resp_valid=0, hw_en=0, busy=0.
  - After rst_n deasserts: req_ready=1.
  - Reset mid-burst aborts immediately: no further hw_en and no response beat for the aborted command.
- Header beat fields:
  - cmd = req_bits[1:0]: 0=READ, 1=WRITE, 2/3=reserved.
  - nm1 = req_bits[15:8]; burst length is nm1+1 beats (1..256).
  - addr = req_bits[32+ADDR_WIDTH-1:32]; low 3 bits forced to 0 (doubleword aligned).
  - All other bits ignored.
- States: IDLE, WDATA, WRESP, RDATA, ERESP.
- IDLE:
  - req_ready=1.
  - On header handshake: latch addr, latch count=nm1, echo nm1 into the status register.
  - Next state: cmd 1 -> WDATA, cmd 0 -> RDATA, cmd 2/3 -> ERESP.
- WDATA:
  - req_ready=1.
  - hw_en = req_valid (combinational); hw_addr = addr register; hw_data = req_bits; hw_mask = all ones.
  - On each handshake: addr += 8 (wraps modulo 2^ADDR_WIDTH); count -= 1.
  - Handshake with count==0 -> WRESP.
  - No hw_en while req_valid is low.
- WRESP:
  - resp_valid=1; resp_bits = {48'b0, nm1[7:0], 6'b0, 2'b00}, status 00 = OK.
  - On resp handshake -> IDLE.
- RDATA:
  - hr_addr = addr register; resp_valid=1; resp_bits = hr_data (zero latency, combinational).
  - On resp handshake: addr += 8 (wraps); count -= 1.
  - Handshake with count==0 -> IDLE.
  - No read response beat is ever dropped or duplicated.
- ERESP:
  - resp_valid=1; resp_bits = {48'b0, nm1, 6'b0, 2'b11}, status 11 = error.
  - No memory access.
  - On resp handshake -> IDLE.
- req_ready=0 in WRESP, RDATA and ERESP; requests are never accepted while a response is pending.
- Backpressure:
  - While resp_valid && !resp_ready, resp_bits and hr_addr hold stable.
  - Memory is not written in RDATA, so hr_data stays stable.
- hw_en is never asserted outside WDATA.
- hr_addr drives the addr register in every state; it is don't-care outside RDATA.
- Back-to-back: an IDLE header handshake may follow a response handshake on the very next cycle.

Test Plan:
- WRITE, addr 0x100, nm1=1; data 0x1122334455667788 then 0xAABBCCDDEEFF0011 -> hw_en pulses at 0x100 then 0x108 with mask 0xFF; then one response beat 0x0000000000000100.
- READ of the same region with resp_ready toggling 1,0,0,1 -> two beats 0x1122334455667788, 0xAABBCCDDEEFF0011; resp_bits constant across stall cycles; busy low afterwards.
- WRITE, addr 0x1FFFF8 (top doubleword), nm1=1 -> second beat written at 0x000000 (wrap); unaligned header addr 0x103 -> writes at 0x100.
- cmd=3, nm1=4 -> single response 0x0000000000000403; hw_en never asserted; next header accepted.
- Assert rst_n low during WDATA beat 2 of 4 -> hw_en drops at once; state IDLE; no response; a fresh READ after reset completes normally.
- req_valid gaps during WDATA (valid 1,0,1) -> exactly nm1+1 writes to consecutive addresses; no hw_en on idle cycles.
